// File: rtl/univ_shift_pkg.sv
// Shared definitions for the universal shift register:
// mode encodings, burst FSM states and a small mode helper.
package univ_shift_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } burst_state_t;

    // True for the two modes that move data serially.
    function automatic logic is_shift_mode(input logic [1:0] m);
        return (m == MODE_SHR) || (m == MODE_SHL);
    endfunction

endpackage

// File: rtl/shift_burst_ctrl.sv
// Burst-shift controller: owns the IDLE/SHIFT/DONE FSM and the remaining-shift
// down-counter. It tells the datapath which operation to perform this cycle
// (dp_op, encoded like mode) and produces busy/done.
module shift_burst_ctrl
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [1:0]       dp_op,
    output logic             busy,
    output logic             done
);

    burst_state_t     state_reg;
    logic [CNT_W-1:0] remain_reg;
    logic [1:0]       dir_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [CNT_W-1:0] count_clamped;
    logic             burst_req;

    // Requests longer than the register are a full flush, nothing more.
    always_comb begin
        count_clamped = count;
        if (count > CNT_W'(WIDTH)) begin
            count_clamped = CNT_W'(WIDTH);
        end
    end

    assign burst_req = start && is_shift_mode(mode);

    // FSM, down-counter and registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            remain_reg <= '0;
            dir_reg    <= MODE_HOLD;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (burst_req) begin
                        dir_reg  <= mode;
                        busy_reg <= 1'b1;
                        if (count_clamped == '0) begin
                            state_reg  <= ST_DONE;
                            remain_reg <= '0;
                            done_reg   <= 1'b1;
                        end else begin
                            // First shift happens on this edge via dp_op.
                            state_reg  <= ST_SHIFT;
                            remain_reg <= count_clamped - CNT_W'(1);
                        end
                    end else begin
                        busy_reg <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    busy_reg <= 1'b1;
                    if (remain_reg == '0) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        remain_reg <= remain_reg - CNT_W'(1);
                        done_reg   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    remain_reg <= '0;
                    busy_reg   <= 1'b0;
                    done_reg   <= 1'b0;
                end
            endcase
        end
    end

    // Operation the datapath applies on the coming edge.
    always_comb begin
        dp_op = MODE_HOLD;
        case (state_reg)
            ST_IDLE: begin
                // A zero-length burst must not disturb q.
                if (burst_req && (count_clamped == '0)) begin
                    dp_op = MODE_HOLD;
                end else begin
                    dp_op = mode;
                end
            end
            ST_SHIFT: begin
                dp_op = (remain_reg != '0) ? dir_reg : MODE_HOLD;
            end
            default: dp_op = MODE_HOLD;
        endcase
    end

    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, parallel load, single-cycle shifts both
// ways, plus a counted burst-shift engine (shift_burst_ctrl).
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    logic [1:0]       dp_op;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] shr_val;
    logic [WIDTH-1:0] shl_val;

    shift_burst_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .start (start),
        .count (count),
        .dp_op (dp_op),
        .busy  (busy),
        .done  (done)
    );

    // Per-bit neighbour selection for both shift directions.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (gi == WIDTH - 1) begin : g_top
            assign shr_val[gi] = sin_r;
        end else begin : g_mid_r
            assign shr_val[gi] = q_reg[gi+1];
        end
        if (gi == 0) begin : g_bot
            assign shl_val[gi] = sin_l;
        end else begin : g_mid_l
            assign shl_val[gi] = q_reg[gi-1];
        end
    end

    // 4-way next-state mux driven by the controller's chosen operation.
    always_comb begin
        q_next = q_reg;
        case (dp_op)
            MODE_SHR:  q_next = shr_val;
            MODE_SHL:  q_next = shl_val;
            MODE_LOAD: q_next = d;
            default:   q_next = q_reg;
        endcase
    end

    // Datapath register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q      = q_reg;
    assign sout_r = q_reg[0];
    assign sout_l = q_reg[WIDTH-1];

endmodule
